// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port between NB_REQ requesters.
// Round-robin grant, registered replay of the winner's transfer as a clean
// SETUP/ACCESS pair. The response is routed only to the granted requester.
// A watchdog force-completes stuck accesses with an error.
//
// Handshake: the APB requester holds psel and its address/data/direction
// until it sees s_pready. s_pready is a one-cycle completion strobe. It is
// issued only while the granted requester still asserts psel; a response to a
// requester that abandoned its request is dropped.
module apb_master_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   s_paddr,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   s_pwdata,
  input  logic [NB_REQ-1:0]                  s_pwrite,
  input  logic [NB_REQ-1:0]                  s_psel,
  input  logic [NB_REQ-1:0]                  s_penable,
  output logic [NB_REQ*APB_DATA_WIDTH-1:0]   s_prdata,
  output logic [NB_REQ-1:0]                  s_pready,
  output logic [NB_REQ-1:0]                  s_pslverr,
  output logic [APB_ADDR_WIDTH-1:0]          m_paddr,
  output logic [APB_DATA_WIDTH-1:0]          m_pwdata,
  output logic                               m_pwrite,
  output logic                               m_psel,
  output logic                               m_penable,
  input  logic [APB_DATA_WIDTH-1:0]          m_prdata,
  input  logic                               m_pready,
  input  logic                               m_pslverr,
  output logic [NB_REQ-1:0]                  grant_o,
  output logic [1:0]                         dbg_state
);

  localparam int IDX_W = $clog2(NB_REQ);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  g_idx;
  logic [CNT_W-1:0]  wd_cnt;

  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  logic              any_req;
  logic              wd_expire;
  logic              done;

  // s_penable carries no information for arbitration; requests are psel-only.
  logic unused_penable;
  assign unused_penable = ^s_penable;

  assign dbg_state = state;

  // Round-robin pick: scan from last_grant+1 upward, wrapping, first psel wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NB_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NB_REQ);
      if (!any_req && s_psel[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Completion: slave ready, or watchdog hitting its last allowed ACCESS cycle.
  always_comb begin
    wd_expire = WD_EN && (state == ST_ACCESS) && !m_pready && (wd_cnt == WD_LAST);
    done      = (state == ST_ACCESS) && (m_pready || wd_expire);
  end

  // Response routing: only the granted slice sees data/ready/error.
  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = '0;
    if (state == ST_ACCESS && s_psel[g_idx]) begin
      s_pready[g_idx]  = done;
      s_pslverr[g_idx] = done && (wd_expire || m_pslverr);
      s_prdata[int'(g_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH] = wd_expire ? '0 : m_prdata;
    end
  end

  // Transfer sequencer with registered master-port outputs and watchdog.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NB_REQ - 1);
      g_idx      <= '0;
      wd_cnt     <= '0;
      grant_o    <= '0;
      m_paddr    <= '0;
      m_pwdata   <= '0;
      m_pwrite   <= 1'b0;
      m_psel     <= 1'b0;
      m_penable  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            m_paddr   <= s_paddr[int'(win_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            m_pwdata  <= s_pwdata[int'(win_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            m_pwrite  <= s_pwrite[win_idx];
            g_idx     <= win_idx;
            grant_o   <= NB_REQ'(1) << win_idx;
            m_psel    <= 1'b1;
            m_penable <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          m_penable <= 1'b1;
          wd_cnt    <= '0;
          state     <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (done) begin
            m_psel     <= 1'b0;
            m_penable  <= 1'b0;
            grant_o    <= '0;
            last_grant <= g_idx;
            state      <= ST_IDLE;
          end else if (WD_EN && wd_cnt != WD_LAST) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: two requesters, a parametrisable slave model
// (wait states, error, stuck-not-ready) and an expected-response queue.
module tb_apb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  // clock/reset
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic [2*AW-1:0] s_paddr;
  logic [2*DW-1:0] s_pwdata;
  logic [1:0]      s_pwrite, s_psel, s_penable;
  logic [2*DW-1:0] s_prdata;
  logic [1:0]      s_pready, s_pslverr;
  logic [AW-1:0]   m_paddr;
  logic [DW-1:0]   m_pwdata;
  logic            m_pwrite, m_psel, m_penable;
  logic [DW-1:0]   m_prdata;
  logic            m_pready, m_pslverr;
  logic [1:0]      grant_o;
  logic [1:0]      dbg_state;

  apb_master_arbiter #(
    .NB_REQ(2), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
    .s_psel(s_psel), .s_penable(s_penable),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
    .m_psel(m_psel), .m_penable(m_penable),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .grant_o(grant_o), .dbg_state(dbg_state)
  );

  // slave model: ready after slv_waits ACCESS cycles unless stuck
  logic [DW-1:0] slv_rdata;
  logic          slv_err;
  logic          slv_stuck;
  int            slv_waits;
  int            acc_cnt = 0;

  always @(posedge HCLK) acc_cnt <= (m_psel && m_penable && !m_pready) ? acc_cnt + 1 : 0;
  assign m_pready  = m_psel && m_penable && !slv_stuck && (acc_cnt >= slv_waits);
  assign m_prdata  = slv_rdata;
  assign m_pslverr = slv_err;

  // scoreboard: {grant_o, s_pready, s_pslverr, s_prdata}
  logic [69:0] exp_q[$];
  logic [69:0] exp_v, obs;
  int checks = 0;
  int errors = 0;
  bit seen;

  function automatic logic [69:0] mk_exp(input int r, input logic err, input logic [DW-1:0] data);
    logic [1:0] oh;
    logic [2*DW-1:0] pd;
    oh = 2'b01 << r;
    pd = '0;
    pd[r*DW +: DW] = data;
    return {oh, oh, (err ? oh : 2'b00), pd};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    s_paddr[r*AW +: AW]  = a;
    s_pwdata[r*DW +: DW] = d;
    s_pwrite[r]  = w;
    s_penable[r] = 1'b0;
    s_psel[r]    = 1'b1;
  endtask

  task automatic clr_req(input int r);
    s_psel[r]   = 1'b0;
    s_pwrite[r] = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (|s_pready) begin
        hit = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    s_paddr = '0; s_pwdata = '0; s_pwrite = '0; s_psel = '0; s_penable = '0;
    slv_rdata = '0; slv_err = 1'b0; slv_stuck = 1'b0; slv_waits = 0;
    tick(); tick();
    checks++;
    if ({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata} !== '0) begin
      errors++;
      $display("FAIL reset_master: got psel=%b pen=%b pwr=%b addr=%h wdata=%h, expected all 0",
               m_psel, m_penable, m_pwrite, m_paddr, m_pwdata);
    end
    checks++;
    if ({grant_o, s_pready, s_pslverr, s_prdata} !== '0) begin
      errors++;
      $display("FAIL reset_slave_side: got grant=%b pready=%b pslverr=%b prdata=%h, expected 0",
               grant_o, s_pready, s_pslverr, s_prdata);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    HRESETn = 1'b1;
    tick();
  endtask

  // Three phases: pair (0 then 1), single req0, pair (1 then 0).
  task automatic test_simultaneous();
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rd[2], prd[2];
    logic          rw[2];
    int            ord[2];
    int            n, r;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 2; i++) begin
        ra[i]  = $urandom;
        rd[i]  = $urandom;
        rw[i]  = 1'($urandom_range(0, 1));
        prd[i] = $urandom;
      end
      n = (p == 1) ? 1 : 2;
      ord[0] = (p == 2) ? 1 : 0;
      ord[1] = (p == 2) ? 0 : 1;
      set_req(0, ra[0], rd[0], rw[0]);
      if (p != 1) set_req(1, ra[1], rd[1], rw[1]);
      for (int j = 0; j < n; j++) exp_q.push_back(mk_exp(ord[j], 1'b0, prd[j]));
      for (int j = 0; j < n; j++) begin
        r = ord[j];
        slv_rdata = prd[j];
        wait_resp(20, seen);
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL rr_phase%0d_xfer%0d: no s_pready within budget", p, j);
        end else begin
          exp_v = exp_q.pop_front();
          obs   = {grant_o, s_pready, s_pslverr, s_prdata};
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL rr_phase%0d_xfer%0d: got %h expected %h", p, j, obs, exp_v);
          end
        end
        checks++;
        if ({m_paddr, m_pwdata, m_pwrite} !== {ra[r], rd[r], rw[r]}) begin
          errors++;
          $display("FAIL rr_master_fields%0d_%0d: got %h/%h/%b expected %h/%h/%b",
                   p, j, m_paddr, m_pwdata, m_pwrite, ra[r], rd[r], rw[r]);
        end
        tick();
        clr_req(r);
      end
    end
  endtask

  task automatic test_read();
    slv_rdata = 32'hDEAD_BEEF;
    slv_waits = 0;
    set_req(0, 32'h1A10_1000, 32'($urandom), 1'b0);
    exp_q.push_back(mk_exp(0, 1'b0, 32'hDEAD_BEEF));
    tick();
    checks++;
    if ({m_psel, m_penable, s_pready, m_paddr} !== {2'b10, 2'b00, 32'h1A10_1000}) begin
      errors++;
      $display("FAIL read_setup: got psel=%b pen=%b pready=%b addr=%h expected 1 0 00 1a101000",
               m_psel, m_penable, s_pready, m_paddr);
    end
    tick();
    checks++;
    if ({m_psel, m_penable} !== 2'b11) begin
      errors++;
      $display("FAIL read_access: got psel=%b pen=%b expected 1 1", m_psel, m_penable);
    end
    checks++;
    exp_v = exp_q.pop_front();
    obs   = {grant_o, s_pready, s_pslverr, s_prdata};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL read_resp_t2: got %h expected %h", obs, exp_v);
    end
    tick();
    clr_req(0);
    checks++;
    if ({m_psel, m_penable, grant_o, dbg_state} !== '0) begin
      errors++;
      $display("FAIL read_idle: got psel=%b pen=%b grant=%b state=%0d expected 0",
               m_psel, m_penable, grant_o, dbg_state);
    end
  endtask

  task automatic test_wait_states();
    logic [AW-1:0] a;
    int rises, at;
    a = $urandom;
    slv_waits = 3;
    slv_rdata = $urandom;
    rises = 0;
    at = -1;
    set_req(0, a, 32'h0000_00A5, 1'b1);
    exp_q.push_back(mk_exp(0, 1'b0, slv_rdata));
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({m_paddr, m_pwdata, m_pwrite, m_psel} !== {a, 32'h0000_00A5, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL wait_stable_c%0d: got %h/%h/%b/%b expected %h/000000a5/1/1",
                 c, m_paddr, m_pwdata, m_pwrite, m_psel, a);
      end
      if (|s_pready) begin
        rises++;
        at = c;
        checks++;
        exp_v = exp_q.pop_front();
        obs   = {grant_o, s_pready, s_pslverr, s_prdata};
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL wait_resp: got %h expected %h", obs, exp_v);
        end
      end
      tick();
    end
    clr_req(0);
    checks++;
    if (rises != 1 || at != 4) begin
      errors++;
      $display("FAIL wait_pready_once: got %0d strobes at cycle %0d expected 1 at cycle 4", rises, at);
    end
    slv_waits = 0;
  endtask

  task automatic test_slverr();
    slv_err   = 1'b1;
    slv_rdata = $urandom;
    set_req(1, 32'($urandom), 32'($urandom), 1'b0);
    exp_q.push_back(mk_exp(1, 1'b1, slv_rdata));
    wait_resp(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL slverr_resp: no s_pready within budget");
    end else begin
      exp_v = exp_q.pop_front();
      obs   = {grant_o, s_pready, s_pslverr, s_prdata};
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL slverr_resp: got %h expected %h", obs, exp_v);
      end
    end
    tick();
    clr_req(1);
    slv_err = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    slv_stuck = 1'b1;
    slv_rdata = $urandom;
    n = 0;
    set_req(0, 32'($urandom), 32'($urandom), 1'b0);
    exp_q.push_back(mk_exp(0, 1'b1, '0));
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (|s_pready) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_cycle: got strobe in ACCESS cycle %0d expected %0d", n, TO);
    end
    if (n != 0) begin
      checks++;
      exp_v = exp_q.pop_front();
      obs   = {grant_o, s_pready, s_pslverr, s_prdata};
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL timeout_resp: got %h expected %h", obs, exp_v);
      end
    end
    tick();
    clr_req(0);
    slv_stuck = 1'b0;
    checks++;
    if ({dbg_state, m_psel, m_penable} !== '0) begin
      errors++;
      $display("FAIL timeout_idle: got state=%0d psel=%b pen=%b expected 0", dbg_state, m_psel, m_penable);
    end
    slv_rdata = $urandom;
    set_req(1, 32'($urandom), 32'($urandom), 1'b0);
    exp_q.push_back(mk_exp(1, 1'b0, slv_rdata));
    wait_resp(20, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_next: no s_pready within budget");
    end else begin
      exp_v = exp_q.pop_front();
      obs   = {grant_o, s_pready, s_pslverr, s_prdata};
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL timeout_next: got %h expected %h", obs, exp_v);
      end
    end
    tick();
    clr_req(1);
  endtask

  task automatic test_reset_mid();
    slv_waits = 5;
    set_req(1, 32'($urandom), 32'($urandom), 1'b1);
    tick();
    tick();
    checks++;
    if (m_penable !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_access: got pen=%b expected 1", m_penable);
    end
    HRESETn = 1'b0;
    clr_req(0);
    clr_req(1);
    tick();
    checks++;
    if ({m_psel, m_penable, grant_o, s_pready} !== '0) begin
      errors++;
      $display("FAIL rstmid_abort: got psel=%b pen=%b grant=%b pready=%b expected 0",
               m_psel, m_penable, grant_o, s_pready);
    end
    tick();
    slv_waits = 0;
    HRESETn = 1'b1;
    slv_rdata = $urandom;
    set_req(0, 32'($urandom), 32'($urandom), 1'b0);
    set_req(1, 32'($urandom), 32'($urandom), 1'b0);
    exp_q.push_back(mk_exp(0, 1'b0, slv_rdata));
    exp_q.push_back(mk_exp(1, 1'b0, slv_rdata));
    for (int j = 0; j < 2; j++) begin
      wait_resp(20, seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rstmid_after%0d: no s_pready within budget", j);
      end else begin
        exp_v = exp_q.pop_front();
        obs   = {grant_o, s_pready, s_pslverr, s_prdata};
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL rstmid_after%0d: got %h expected %h", j, obs, exp_v);
        end
      end
      tick();
      clr_req(j);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_read();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_reset_mid();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port between `NB_REQ` APB requesters, such as the core data bridge and the debug/SPI-slave path, ahead of the peripheral APB interconnect. Each requester presents an APB slave-side port. The arbiter grants one requester at a time in round-robin order and registers its address, data and direction. It replays the transfer on the shared master port as a clean SETUP/ACCESS pair and returns the response to the granted requester only. A watchdog terminates any access the downstream slave never completes, flagging it with `pslverr`.

## Interface
Parameters:
- `NB_REQ`, 2: number of requesters, at least 2.
- `APB_ADDR_WIDTH`, 32: address width.
- `APB_DATA_WIDTH`, 32: data width.
- `TIMEOUT_CYCLES`, 256: maximum ACCESS cycles before forced error completion. 0 disables the watchdog.

Ports. Clock and reset: one clock; reset is synchronous and active-low. Requester-side ports are packed, with requester i in slice i.
- `HCLK` in, 1: clock. All logic is on its rising edge.
- `HRESETn` in, 1: synchronous active-low reset.
- `s_paddr` in, NB_REQ*APB_ADDR_WIDTH: requester addresses.
- `s_pwdata` in, NB_REQ*APB_DATA_WIDTH: requester write data.
- `s_pwrite` in, NB_REQ: requester directions.
- `s_psel` in, NB_REQ: requester selects.
- `s_penable` in, NB_REQ: requester enables. Ignored for arbitration.
- `s_prdata` out, NB_REQ*APB_DATA_WIDTH: read data to requesters.
- `s_pready` out, NB_REQ: completion strobe per requester.
- `s_pslverr` out, NB_REQ: error per requester, valid with `s_pready`.
- `m_paddr` out, APB_ADDR_WIDTH: shared master address.
- `m_pwdata` out, APB_DATA_WIDTH: shared master write data.
- `m_pwrite` out, 1: shared master direction.
- `m_psel` out, 1: shared master select.
- `m_penable` out, 1: shared master enable.
- `m_prdata` in, APB_DATA_WIDTH: read data from the slave.
- `m_pready` in, 1: ready from the slave.
- `m_pslverr` in, 1: error from the slave.
- `grant_o` out, NB_REQ: one-hot index of the current owner; all zero in IDLE.

## Operation
State machine:
- IDLE
  - If any `s_psel` bit is 1, pick the winner round-robin, starting from `last_grant+1` and wrapping modulo NB_REQ.
  - Register the winner's paddr, pwdata and pwrite into the master outputs, set `grant_o`, and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: `m_psel`=1, `m_penable`=0. Always go to ACCESS next cycle. Clear the watchdog counter.
- ACCESS: `m_psel`=1, `m_penable`=1.
  - Completion is `m_pready`=1, or watchdog expiry. On completion, go to IDLE, drop `m_psel`/`m_penable` on that edge, and update `last_grant` to the winner.
  - Otherwise increment the watchdog counter.
- Watchdog expiry: counter equals TIMEOUT_CYCLES-1 with `m_pready`=0.

Response path (combinational in ACCESS):
- `s_pready[g]` = completion.
- `s_prdata[g]` = `m_prdata`, or 0 on timeout.
- `s_pslverr[g]` = `m_pslverr`, or 1 on timeout.
- Every non-granted slice drives pready=0, pslverr=0, prdata=0.

Requester contract: a requester holds `psel` and its address, data and direction stable until it sees its `s_pready`. Master outputs are registered, so requester-side changes after the grant have no effect.

Reset values:
- `m_psel`, `m_penable`, `m_pwrite` = 0.
- `m_paddr`, `m_pwdata` = 0.
- `grant_o` = 0.
- All `s_*` outputs = 0.
- State = IDLE; watchdog counter = 0.
- `last_grant` = NB_REQ-1, so requester 0 has first priority.

Boundary conditions:
- Simultaneous requests are served one per transfer in rotating order; no requester waits more than NB_REQ-1 transfers.
- The watchdog counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.
- Reset asserted mid-transfer: the master port returns to idle on that edge and no `s_pready` is issued.
- A requester that drops `psel` before completion violates its contract. The transfer still completes on the master port; the response is discarded.

## Timing
- Request sampled in IDLE at cycle T; SETUP at T+1; ACCESS at T+2.
- Zero-wait slave: requester sees `s_pready`=1 at T+2, giving 3 cycles of latency.
- Each slave wait state adds one cycle.
- Minimum 3 cycles per transfer. A back-to-back request present in the cycle after completion is sampled in that IDLE cycle.
- Watchdog error: `s_pready`/`s_pslverr`=1 in the TIMEOUT_CYCLES-th ACCESS cycle.

## Test plan
- Req0 reads 0x1A10_1000 with a zero-wait slave returning 0xDEAD_BEEF: `m_psel` high T+1..T+2, `m_penable` at T+2, `s_pready[0]`=1 at T+2, `s_prdata[0]`=0xDEAD_BEEF, `s_prdata[1]`=0.
- Req0 writes 0x1A10_2000 and req1 writes 0x1A10_3000 in the same cycle after reset: req0 is served first, then req1. The next simultaneous pair is served req1 first only if req0 was last, confirming the rotation.
- Slave inserts 3 wait states on a write of 0x0000_00A5: `m_paddr`/`m_pwdata` stay stable for 5 cycles, and `s_pready` rises exactly once, on the cycle `m_pready`=1.
- Slave returns `m_pslverr`=1: `s_pslverr[g]`=1 with `s_pready[g]`; the other slice stays 0.
- TIMEOUT_CYCLES=8 with `m_pready` stuck at 0: after 8 ACCESS cycles, `s_pready`=1, `s_pslverr`=1, `s_prdata`=0, state returns to IDLE, and the next request is served normally.
- `HRESETn` pulled low during ACCESS: on the next edge `m_psel`=0, `m_penable`=0, `grant_o`=0, all `s_pready`=0; after release, req0 has first priority.
